// File: rtl/am_pkg.sv
// Shared definitions for the AM modulator: FSM state encoding and the
// quarter-wave sine table used to build the carrier.
package am_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCALE,
        ENV,
        CARRIER,
        MULT,
        OUT
    } amState_t;

    // Entry i is round(127*sin((i+0.5)*pi/128)); the half-step offset keeps the table symmetric.
    localparam logic [6:0] SINE_LUT [0:63] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    function automatic logic signed [7:0] carrierFromPhase(input logic [7:0] p);
        logic [5:0] idx;
        logic signed [7:0] mag;
        // Odd quadrants read the table backwards (63 - idx == ~idx); the lower half-wave is negated.
        idx = p[6] ? ~p[5:0] : p[5:0];
        mag = {1'b0, SINE_LUT[idx]};
        return p[7] ? -mag : mag;
    endfunction

endpackage

// File: rtl/serial_mult_su.sv
// Serial shift-add multiplier: 8-bit signed times 8-bit unsigned, one partial
// product per clock, eight clocks after start.
module serial_mult_su (
    input  logic               CLK,
    input  logic               RSTb,
    input  logic               start_i,
    input  logic signed [7:0]  a_i,
    input  logic        [7:0]  b_i,
    output logic signed [15:0] product_o,
    output logic               done_o
);

    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  count_q, count_d;
    logic        run_q, run_d;

    // The signed multiplicand is sign-extended once and shifted left; the unsigned multiplier is consumed LSB first.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        run_d    = run_q;
        if (start_i) begin
            mcand_d  = {{8{a_i[7]}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            count_d  = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 3'd1;
            if (count_q == 3'd7) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            run_q    <= run_d;
        end
    end

    // Done flags the clock whose edge performs the last step, so the caller can move on in step with it.
    assign done_o    = run_q && (count_q == 3'd7);
    assign product_o = acc_q;

endmodule

// File: rtl/am_mod_lite.sv
// Lightweight AM modulator: scales audio by depth into an envelope, multiplies
// by a LUT sine carrier, and renders the result as a first-order PDM bitstream.
module am_mod_lite
    import am_pkg::*;
#(
    parameter int AUDIO_BITS = 16,
    parameter int PHASE_BITS = 24
) (
    input  logic                         CLK,
    input  logic                         RSTb,
    input  logic signed [AUDIO_BITS-1:0] audio_in,
    input  logic                         load_tick,
    input  logic        [PHASE_BITS-1:0] phase_inc,
    input  logic        [7:0]            mod_depth,
    output logic signed [AUDIO_BITS-1:0] rf_out,
    output logic                         out_tick,
    output logic                         busy,
    output logic                         pdm_out
);

    amState_t state_q, state_d;
    logic [PHASE_BITS-1:0] phaseInc_q, phaseInc_d;
    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic [7:0]            env_q, env_d;
    logic [15:0]           rfOut_q, rfOut_d;
    logic                  outTick_q, outTick_d;
    logic [15:0]           pdmAcc_q, pdmAcc_d;
    logic                  pdmOut_q, pdmOut_d;
    logic [16:0]           pdmSum;

    logic                  multStart;
    logic signed [7:0]     multA;
    logic [7:0]            multB;
    logic signed [15:0]    multProduct;
    logic                  multDone;

    serial_mult_su uMult (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .start_i   (multStart),
        .a_i       (multA),
        .b_i       (multB),
        .product_o (multProduct),
        .done_o    (multDone)
    );

    // One multiplier serves both products: audio*depth is started on acceptance, envelope*carrier in CARRIER.
    always_comb begin
        state_d    = state_q;
        phaseInc_d = phaseInc_q;
        phase_d    = phase_q;
        env_d      = env_q;
        rfOut_d    = rfOut_q;
        outTick_d  = 1'b0;
        multStart  = 1'b0;
        multA      = 8'sd0;
        multB      = 8'd0;
        unique case (state_q)
            IDLE: begin
                if (load_tick) begin
                    multStart  = 1'b1;
                    multA      = audio_in[AUDIO_BITS-1 -: 8];
                    multB      = mod_depth;
                    phaseInc_d = phase_inc;
                    state_d    = SCALE;
                end
            end
            SCALE: begin
                if (multDone) begin
                    state_d = ENV;
                end
            end
            ENV: begin
                // Upper byte of the product is the floor-shifted scale; adding 128 recentres it unsigned.
                env_d   = multProduct[15:8] + 8'd128;
                state_d = CARRIER;
            end
            CARRIER: begin
                multStart = 1'b1;
                multA     = carrierFromPhase(phase_q[PHASE_BITS-1 -: 8]);
                multB     = env_q;
                phase_d   = phase_q + phaseInc_q;
                state_d   = MULT;
            end
            MULT: begin
                if (multDone) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                rfOut_d   = multProduct;
                outTick_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Offset-binary accumulation: the carry rate equals (rf_out + 32768) / 65536.
    always_comb begin
        pdmSum   = {1'b0, pdmAcc_q} + {1'b0, rfOut_q ^ 16'h8000};
        pdmAcc_d = pdmSum[15:0];
        pdmOut_d = pdmSum[16];
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q    <= IDLE;
            phaseInc_q <= '0;
            phase_q    <= '0;
            env_q      <= '0;
            rfOut_q    <= '0;
            outTick_q  <= 1'b0;
            pdmAcc_q   <= '0;
            pdmOut_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phaseInc_q <= phaseInc_d;
            phase_q    <= phase_d;
            env_q      <= env_d;
            rfOut_q    <= rfOut_d;
            outTick_q  <= outTick_d;
            pdmAcc_q   <= pdmAcc_d;
            pdmOut_q   <= pdmOut_d;
        end
    end

    assign rf_out   = rfOut_q;
    assign out_tick = outTick_q;
    assign busy     = (state_q != IDLE);
    assign pdm_out  = pdmOut_q;

endmodule
